// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch unit: PC-addressed memory read into IR with fault reporting
// Fetches one instruction per fetch_start, capturing PC0 for PC-relative targets.
module inst_fetch #(
   parameter int          TIMEOUT  = 15,
   parameter logic [31:0] RESET_IR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_start,
   input  logic [31:0] PC,
   input  logic        fault_clr,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic        mem_err,
   input  logic [31:0] mem_rdata,
   output logic [31:0] IR,
   output logic [31:0] PC0,
   output logic        fetch_done,
   output logic        fetch_fault,
   output logic [1:0]  fault_cause,
   output logic        busy
);

   localparam int            CW     = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] C_MAX  = '1;

   localparam logic [1:0] CAUSE_NONE  = 2'b00;
   localparam logic [1:0] CAUSE_ALIGN = 2'b01;
   localparam logic [1:0] CAUSE_BUS   = 2'b10;
   localparam logic [1:0] CAUSE_TMO   = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_FAULT} state_t;

   state_t        r_state;
   logic [31:0]   r_ir;
   logic [31:0]   r_pc0;
   logic [31:0]   r_addr;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_cause;
   logic          r_mem_req;
   logic          r_done;
   logic          r_fault;
   logic          r_busy;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_ir      <= RESET_IR;
         r_pc0     <= '0;
         r_addr    <= '0;
         r_cnt     <= '0;
         r_cause   <= CAUSE_NONE;
         r_mem_req <= 1'b0;
         r_done    <= 1'b0;
         r_fault   <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (fetch_start) begin
                  r_pc0  <= PC;
                  r_busy <= 1'b1;
                  // A misaligned PC faults immediately without touching the bus.
                  if (PC[1:0] != 2'b00) begin
                     r_cause <= CAUSE_ALIGN;
                     r_fault <= 1'b1;
                     r_state <= S_FAULT;
                  end else begin
                     r_addr    <= PC;
                     r_cnt     <= '0;
                     r_mem_req <= 1'b1;
                     r_state   <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (mem_ready) begin
                  r_mem_req <= 1'b0;
                  if (mem_err) begin
                     r_cause <= CAUSE_BUS;
                     r_fault <= 1'b1;
                     r_state <= S_FAULT;
                  end else begin
                     r_ir    <= mem_rdata;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end else if (r_cnt == C_LAST) begin
                  r_mem_req <= 1'b0;
                  r_cause   <= CAUSE_TMO;
                  r_fault   <= 1'b1;
                  r_state   <= S_FAULT;
               end else if (r_cnt != C_MAX) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            S_FAULT: begin
               if (fault_clr) begin
                  r_cause <= CAUSE_NONE;
                  r_fault <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_mem_req <= 1'b0;
               r_fault   <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign mem_req     = r_mem_req;
   assign mem_addr    = r_addr;
   assign IR          = r_ir;
   assign PC0         = r_pc0;
   assign fetch_done  = r_done;
   assign fetch_fault = r_fault;
   assign fault_cause = r_cause;
   assign busy        = r_busy;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch
// Expected fetch outcomes are queued at stimulus time and compared when done/fault appears.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_start = 1'b0;
   logic [31:0] PC = '0;
   logic        fault_clr = 1'b0;
   logic        mem_ready = 1'b0;
   logic        mem_err = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] IR;
   logic [31:0] PC0;
   logic        fetch_done;
   logic        fetch_fault;
   logic [1:0]  fault_cause;
   logic        busy;

   inst_fetch #(.TIMEOUT(15), .RESET_IR(32'h0000_0013)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .PC(PC), .fault_clr(fault_clr),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_err(mem_err),
      .mem_rdata(mem_rdata), .IR(IR), .PC0(PC0), .fetch_done(fetch_done),
      .fetch_fault(fetch_fault), .fault_cause(fault_cause), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] pc0;
      logic [1:0]  cause;
      logic        fault;
      logic [7:0]  cyc;
      logic [7:0]  nreq;
      logic        addr_ok;
      logic        busy_ok;
   } res_t;

   res_t        sb[$];
   int          vecs = 0;
   int          errs = 0;
   logic [31:0] m_ir = 32'h0000_0013;

   function automatic string fmt(input res_t r);
      return $sformatf("ir=%h pc0=%h cause=%0d fault=%0b cyc=%0d nreq=%0d addr_ok=%0b busy_ok=%0b",
                       r.ir, r.pc0, r.cause, r.fault, r.cyc, r.nreq, r.addr_ok, r.busy_ok);
   endfunction

   function automatic res_t mk(input logic [31:0] ir, input logic [31:0] pc0, input logic [1:0] cause,
                               input logic fault, input int cyc, input int nreq);
      res_t r;
      r.ir = ir; r.pc0 = pc0; r.cause = cause; r.fault = fault;
      r.cyc = 8'(cyc); r.nreq = 8'(nreq); r.addr_ok = 1'b1; r.busy_ok = 1'b1;
      return r;
   endfunction

   // Memory responder: answers after `waits` stall cycles unless `never` is set.
   task automatic run_fetch(input logic [31:0] pc, input int waits, input logic [31:0] rd,
                            input logic err, input bit never, output res_t o);
      o = '0;
      o.cyc = 8'hFF; o.addr_ok = 1'b1; o.busy_ok = 1'b1;
      @(negedge clk); PC = pc; fetch_start = 1'b1;
      @(negedge clk); fetch_start = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         if (!busy) o.busy_ok = 1'b0;
         if (mem_req) begin
            o.nreq = o.nreq + 8'd1;
            if (mem_addr !== pc) o.addr_ok = 1'b0;
         end
         if (fetch_done || fetch_fault) begin
            o.cyc = 8'(c);
            break;
         end
         if (mem_req && !never && int'(o.nreq) == waits + 1) begin
            mem_ready = 1'b1; mem_err = err; mem_rdata = rd;
         end
         @(negedge clk);
         mem_ready = 1'b0; mem_err = 1'b0; mem_rdata = 32'hDEAD_BEEF;
      end
      o.ir = IR; o.pc0 = PC0; o.cause = fault_cause; o.fault = fetch_fault;
   endtask

   task automatic clear_fault();
      @(negedge clk); fault_clr = 1'b1;
      @(negedge clk); fault_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      vecs++; if (mem_req !== 1'b0) begin errs++; $display("FAIL rst_mem_req got %b want 0", mem_req); end
      vecs++; if (IR !== 32'h13) begin errs++; $display("FAIL rst_ir got %h want 00000013", IR); end
      vecs++; if (PC0 !== 32'h0) begin errs++; $display("FAIL rst_pc0 got %h want 0", PC0); end
      vecs++; if (mem_addr !== 32'h0) begin errs++; $display("FAIL rst_addr got %h want 0", mem_addr); end
      vecs++; if ({fetch_done, fetch_fault, busy} !== 3'b000) begin errs++; $display("FAIL rst_flags got %b want 000", {fetch_done, fetch_fault, busy}); end
      vecs++; if (fault_cause !== 2'b00) begin errs++; $display("FAIL rst_cause got %b want 00", fault_cause); end
      rst_n = 1'b1;
      m_ir = 32'h13;
   endtask

   task automatic test_zero_wait();
      res_t o, e;
      sb.push_back(mk(32'h0050_0093, 32'h100, 2'b00, 1'b0, 2, 1));
      run_fetch(32'h100, 0, 32'h0050_0093, 1'b0, 1'b0, o);
      m_ir = 32'h0050_0093;
      e = sb.pop_front();
      vecs++; if (o !== e) begin errs++; $display("FAIL zero_wait got %s want %s", fmt(o), fmt(e)); end
      @(negedge clk);
      vecs++; if ({fetch_done, busy} !== 2'b00) begin errs++; $display("FAIL done_pulse got done,busy=%b want 00", {fetch_done, busy}); end
   endtask

   task automatic test_wait_states();
      res_t o, e;
      sb.push_back(mk(32'hFE00_0EE3, 32'h200, 2'b00, 1'b0, 5, 4));
      run_fetch(32'h200, 3, 32'hFE00_0EE3, 1'b0, 1'b0, o);
      m_ir = 32'hFE00_0EE3;
      e = sb.pop_front();
      vecs++; if (o !== e) begin errs++; $display("FAIL wait3 got %s want %s", fmt(o), fmt(e)); end
   endtask

   task automatic test_misaligned();
      res_t o, e;
      sb.push_back(mk(m_ir, 32'h102, 2'b01, 1'b1, 1, 0));
      run_fetch(32'h102, 0, 32'h1111_1111, 1'b0, 1'b0, o);
      e = sb.pop_front();
      vecs++; if (o !== e) begin errs++; $display("FAIL misalign got %s want %s", fmt(o), fmt(e)); end
      clear_fault();
      vecs++; if ({fetch_fault, fault_cause, busy} !== 4'b0000) begin errs++; $display("FAIL misalign_clr got fault,cause,busy=%b want 0000", {fetch_fault, fault_cause, busy}); end
   endtask

   task automatic test_bus_err();
      res_t o, e;
      sb.push_back(mk(m_ir, 32'h400, 2'b10, 1'b1, 3, 2));
      run_fetch(32'h400, 1, 32'h2222_2222, 1'b1, 1'b0, o);
      e = sb.pop_front();
      vecs++; if (o !== e) begin errs++; $display("FAIL bus_err got %s want %s", fmt(o), fmt(e)); end
      @(negedge clk); PC = 32'h500; fetch_start = 1'b1;
      @(negedge clk); fetch_start = 1'b0;
      @(negedge clk);
      vecs++; if ({fetch_fault, fault_cause, mem_req} !== 4'b1100) begin errs++; $display("FAIL start_in_fault got fault,cause,req=%b want 1100", {fetch_fault, fault_cause, mem_req}); end
      vecs++; if (PC0 !== 32'h400) begin errs++; $display("FAIL start_in_fault_pc0 got %h want 00000400", PC0); end
      clear_fault();
      vecs++; if ({fetch_fault, fault_cause, busy} !== 4'b0000) begin errs++; $display("FAIL bus_err_clr got fault,cause,busy=%b want 0000", {fetch_fault, fault_cause, busy}); end
   endtask

   task automatic test_timeout();
      res_t o, e;
      sb.push_back(mk(m_ir, 32'h600, 2'b11, 1'b1, 16, 15));
      run_fetch(32'h600, 0, 32'h0, 1'b0, 1'b1, o);
      e = sb.pop_front();
      vecs++; if (o !== e) begin errs++; $display("FAIL timeout got %s want %s", fmt(o), fmt(e)); end
      clear_fault();
      vecs++; if ({fetch_fault, fault_cause} !== 3'b000) begin errs++; $display("FAIL timeout_clr got fault,cause=%b want 000", {fetch_fault, fault_cause}); end
   endtask

   task automatic test_timeout_edge();
      res_t o, e;
      sb.push_back(mk(32'h1234_5678, 32'h700, 2'b00, 1'b0, 16, 15));
      run_fetch(32'h700, 14, 32'h1234_5678, 1'b0, 1'b0, o);
      m_ir = 32'h1234_5678;
      e = sb.pop_front();
      vecs++; if (o !== e) begin errs++; $display("FAIL ready_at_last got %s want %s", fmt(o), fmt(e)); end
   endtask

   task automatic test_back_to_back();
      res_t o, e;
      logic [31:0] data;
      for (int i = 0; i < 3; i++) begin
         data = $urandom;
         sb.push_back(mk(data, 32'h800 + 32'(i * 4), 2'b00, 1'b0, 2, 1));
         run_fetch(32'h800 + 32'(i * 4), 0, data, 1'b0, 1'b0, o);
         m_ir = data;
         e = sb.pop_front();
         vecs++; if (o !== e) begin errs++; $display("FAIL b2b_%0d got %s want %s", i, fmt(o), fmt(e)); end
      end
   endtask

   task automatic test_reset_mid_req();
      @(negedge clk); PC = 32'h300; fetch_start = 1'b1;
      @(negedge clk); fetch_start = 1'b0;
      @(negedge clk);
      vecs++; if (mem_req !== 1'b1) begin errs++; $display("FAIL mid_req_pre got mem_req=%b want 1", mem_req); end
      rst_n = 1'b0; fetch_start = 1'b1; PC = 32'h304;
      @(negedge clk);
      vecs++; if ({mem_req, busy} !== 2'b00) begin errs++; $display("FAIL mid_req_rst got req,busy=%b want 00", {mem_req, busy}); end
      vecs++; if (IR !== 32'h13 || PC0 !== 32'h0) begin errs++; $display("FAIL mid_req_regs got ir=%h pc0=%h want 00000013 00000000", IR, PC0); end
      rst_n = 1'b1; fetch_start = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hAAAA_5555;
      @(negedge clk); mem_ready = 1'b0;
      m_ir = 32'h13;
      vecs++; if (IR !== m_ir || fetch_done !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL late_ready got ir=%h done=%b busy=%b want %h 0 0", IR, fetch_done, busy, m_ir); end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_misaligned();
      test_bus_err();
      test_timeout();
      test_timeout_edge();
      test_back_to_back();
      test_reset_mid_req();
      test_zero_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
